bloco_operativo: RTL and testbench

- Datapath stage directly downstream of the `controle` FSM. It consumes that FSM's `lx`/`m0`/`m1`/`m2`/`h`/`ls`/`lh` strobes and evaluates s = KA·(x² + KB) + KC.
- Holds registers X, H (accumulator) and S (result). It has a single-cycle adder and an iterative W-cycle shift-add multiplier.
- Drives `pronto` back to the controller and presents `s_out` to the consumer.

---
 rtl/bloco_operativo.sv | 188 ++++++++++++++++++
 tb/tb_bloco_operativo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bloco_operativo.sv
// Datapath for s = KA*(x^2 + KB) + KC: X/H/S registers, a one-cycle adder and a W-step shift-add multiplier.
// Optional sticky overflow output `ovf` is built only when OVERFLOW_FLAG_EN is defined.
module bloco_operativo #(
    parameter int           W  = 8,
    parameter logic [W-1:0] KA = W'(2),
    parameter logic [W-1:0] KB = W'(3),
    parameter logic [W-1:0] KC = W'(5)
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         lx,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    input  logic         h,
    input  logic         ls,
    input  logic         lh,
    output logic [W-1:0] s_out,
    output logic         pronto,
    output logic         ocupado
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic         ovf
`endif
);

    localparam logic OCIOSO = 1'b0;
    localparam logic MULT   = 1'b1;

`ifdef OVERFLOW_FLAG_EN
    localparam int AW = 2 * W;
    localparam int SW = W + 1;
`else
    localparam int AW = W;
    localparam int SW = W;
`endif

    logic [W-1:0]  x_r;
    logic [W-1:0]  h_r;
    logic [W-1:0]  s_r;
    logic          state_r;
    logic [W-1:0]  cnt_r;
    logic [AW-1:0] acc_r;
    logic [AW-1:0] mcand_r;
    logic [W-1:0]  mplier_r;
    logic          pronto_r;

    logic [W-1:0]  p_s;
    logic [W-1:0]  q_s;
    logic [SW-1:0] sum_s;
    logic [AW-1:0] acc_next_s;
    logic          add_go_s;
    logic          mul_go_s;
    logic          mul_done_s;

    // Left operand mux: m1 overrides m0 whenever it is nonzero
    always_comb begin
        p_s = h_r;
        case (m1)
            2'b01:   p_s = KA;
            2'b10:   p_s = KB;
            2'b11:   p_s = KC;
            default: begin
                case (m0)
                    2'b00:   p_s = h_r;
                    2'b01:   p_s = x_r;
                    2'b10:   p_s = KB;
                    default: p_s = KC;
                endcase
            end
        endcase
    end

    // Right operand mux
    always_comb begin
        q_s = x_r;
        case (m2)
            2'b00:   q_s = x_r;
            2'b01:   q_s = KA;
            2'b10:   q_s = KB;
            default: q_s = h_r;
        endcase
    end

    // Adder, command decode and the next multiplier accumulator value
    always_comb begin
        sum_s      = SW'(p_s) + SW'(q_s);
        add_go_s   = lh && !h && (state_r == OCIOSO);
        mul_go_s   = lh && h && (state_r == OCIOSO);
        mul_done_s = (state_r == MULT) && (cnt_r == W'(W - 1));
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // X and S registers; both accept writes regardless of multiplier state
    always_ff @(posedge ck) begin
        if (rst) begin
            x_r <= {W{1'b0}};
            s_r <= {W{1'b0}};
        end else begin
            if (lx) begin
                x_r <= x_in;
            end
            if (ls) begin
                s_r <= sum_s[W-1:0];
            end
        end
    end

    // Multiplier FSM and H: operands are captured at acceptance so later mux changes do not matter
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r  <= OCIOSO;
            cnt_r    <= {W{1'b0}};
            acc_r    <= {AW{1'b0}};
            mcand_r  <= {AW{1'b0}};
            mplier_r <= {W{1'b0}};
            h_r      <= {W{1'b0}};
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (mul_go_s) begin
                        state_r  <= MULT;
                        cnt_r    <= {W{1'b0}};
                        acc_r    <= {AW{1'b0}};
                        mcand_r  <= AW'(p_s);
                        mplier_r <= q_s;
                    end else if (add_go_s) begin
                        h_r <= sum_s[W-1:0];
                    end
                end
                MULT: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + W'(1);
                    if (mul_done_s) begin
                        h_r     <= acc_next_s[W-1:0];
                        state_r <= OCIOSO;
                    end
                end
                default: state_r <= OCIOSO;
            endcase
        end
    end

    // One-cycle completion pulse after any H write
    always_ff @(posedge ck) begin
        if (rst) begin
            pronto_r <= 1'b0;
        end else begin
            pronto_r <= add_go_s || mul_done_s;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_r;
    logic ovf_set_s;

    // Overflow on this edge: sum carry-out or nonzero product high half
    always_comb begin
        ovf_set_s = ((ls || add_go_s) && sum_s[W])
                 || (mul_done_s && (acc_next_s[AW-1:W] != {W{1'b0}}));
    end

    // Sticky flag; an overflow on the clearing edge still wins
    always_ff @(posedge ck) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (lx) begin
            ovf_r <= ovf_set_s;
        end else begin
            ovf_r <= ovf_r || ovf_set_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign s_out   = s_r;
    assign pronto  = pronto_r;
    assign ocupado = state_r;

endmodule

// File: tb/tb_bloco_operativo.sv
// Directed bench for bloco_operativo: expected H values go through a scoreboard queue and are
// read back through S (S = H + KA) once `pronto` announces the write.
module tb_bloco_operativo;

    logic       ck;
    logic       rst;
    logic [7:0] x_in;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic [7:0] s_out;
    logic       pronto;
    logic       ocupado;
`ifdef OVERFLOW_FLAG_EN
    logic       ovf;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic [7:0] e_h;

    bloco_operativo #(.W(8), .KA(8'd2), .KB(8'd3), .KC(8'd5)) dut (
        .ck      (ck),
        .rst     (rst),
        .x_in    (x_in),
        .lx      (lx),
        .m0      (m0),
        .m1      (m1),
        .m2      (m2),
        .h       (h),
        .ls      (ls),
        .lh      (lh),
        .s_out   (s_out),
        .pronto  (pronto),
        .ocupado (ocupado)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic clr();
        lx = 1'b0; ls = 1'b0; lh = 1'b0; h = 1'b0;
        m0 = 2'b00; m1 = 2'b00; m2 = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_x(input logic [7:0] v);
        x_in = v;
        lx   = 1'b1;
        tick();
        lx   = 1'b0;
    endtask

    // S <= H + KA, then compare with the expected H plus 2
    task automatic read_h(input string tag, input logic [7:0] exp_h);
        logic [7:0] e;
        e  = exp_h + 8'd2;
        clr();
        m2 = 2'b01;
        ls = 1'b1;
        tick();
        ls = 1'b0;
        chk(tag, {8'd0, s_out}, {8'd0, e});
    endtask

    task automatic wait_pronto(input string tag);
        int n;
        n = 0;
        while (pronto !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {15'd0, pronto}, 16'd1);
        chk("sb_nonempty", {15'd0, sb.size() != 0}, 16'd1);
        if (pronto === 1'b1 && sb.size() != 0) begin
            e_h = sb.pop_front();
            read_h(tag, e_h);
        end
    endtask

    initial begin
        clr();
        x_in = 8'd0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        chk("rst_s_out", {8'd0, s_out}, 16'd0);
        chk("rst_pronto", {15'd0, pronto}, 16'd0);
        chk("rst_ocupado", {15'd0, ocupado}, 16'd0);
`ifdef OVERFLOW_FLAG_EN
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
`endif
        read_h("rst_h", 8'd0);

        // Full evaluation sequence with x = 4
        load_x(8'd4);
        m0 = 2'b01; m2 = 2'b00; h = 1'b1; lh = 1'b1; sb.push_back(8'd16);
        tick(); clr();
        chk("seq_busy", {15'd0, ocupado}, 16'd1);
        wait_pronto("seq_x2");
        m0 = 2'b10; m2 = 2'b11; h = 1'b0; lh = 1'b1; sb.push_back(8'd19);
        tick(); clr();
        chk("seq_add_pronto", {15'd0, pronto}, 16'd1);
        wait_pronto("seq_add");
        m1 = 2'b01; m2 = 2'b11; h = 1'b1; lh = 1'b1; sb.push_back(8'd38);
        tick(); clr();
        wait_pronto("seq_mul_ka");
        m0 = 2'b11; m2 = 2'b11; ls = 1'b1;
        tick(); clr();
        chk("seq_s43", {8'd0, s_out}, 16'd43);
        chk("seq_ls_no_pronto", {15'd0, pronto}, 16'd0);
`ifdef OVERFLOW_FLAG_EN
        chk("seq_no_ovf", {15'd0, ovf}, 16'd0);
`endif

        // Multiply timing, with an ignored lh and an X change mid-flight
        m0 = 2'b01; m2 = 2'b00; h = 1'b1; lh = 1'b1; sb.push_back(8'd16);
        tick(); clr();
        for (int k = 1; k <= 8; k++) begin
            chk("mt_busy", {15'd0, ocupado}, 16'd1);
            chk("mt_no_pronto", {15'd0, pronto}, 16'd0);
            if (k == 3) begin
                lh = 1'b1; h = 1'b0; m0 = 2'b10; x_in = 8'd9; lx = 1'b1;
            end else begin
                clr();
            end
            tick();
        end
        chk("mt_idle_e8", {15'd0, ocupado}, 16'd0);
        chk("mt_pronto_e8", {15'd0, pronto}, 16'd1);
        e_h = sb.pop_front();
        tick();
        chk("mt_pronto_once", {15'd0, pronto}, 16'd0);
        read_h("mt_h", e_h);

        // Wrap-around: 20*20 mod 256
        load_x(8'd20);
        m0 = 2'b01; m2 = 2'b00; h = 1'b1; lh = 1'b1; sb.push_back(8'd144);
        tick(); clr();
        wait_pronto("wrap_h");
`ifdef OVERFLOW_FLAG_EN
        chk("wrap_ovf_set", {15'd0, ovf}, 16'd1);
`endif
        load_x(8'd20);
`ifdef OVERFLOW_FLAG_EN
        chk("wrap_ovf_clr", {15'd0, ovf}, 16'd0);
`endif

        // Reset at e4 of a multiply aborts it without an H write
        m0 = 2'b01; m2 = 2'b01; h = 1'b1; lh = 1'b1;
        tick(); clr();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ocupado", {15'd0, ocupado}, 16'd0);
        chk("abort_s_out", {8'd0, s_out}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            chk("abort_no_pronto", {15'd0, pronto}, 16'd0);
            tick();
        end
        read_h("abort_h", 8'd0);

        // ls and lh add on the same edge
        load_x(8'd7);
        m0 = 2'b10; m2 = 2'b00; h = 1'b0; lh = 1'b1; ls = 1'b1; sb.push_back(8'd10);
        tick(); clr();
        chk("dual_s", {8'd0, s_out}, 16'd10);
        wait_pronto("dual_h");

        chk("sb_drained", sb.size(), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
